// File: rtl/gb_oam_dma.sv
// OAM DMA controller: a write to $FF46 copies NUM_BYTES bytes from page XX00 into OAM,
// one byte every BYTE_CLKS clocks, after a one-byte start delay.
module gb_oam_dma #(
  parameter int BYTE_CLKS = 4,
  parameter int NUM_BYTES = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  reg_rdata,
  output logic        cpu_block,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_wr,
  output logic        dma_active
);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  localparam logic [3:0] CNT_LAST = 4'(BYTE_CLKS - 1);
  localparam logic [7:0] IDX_LAST = 8'(NUM_BYTES - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [7:0] idx_reg, idx_next;
  logic [7:0] src_hi_reg, src_hi_next;
  logic [7:0] reg_rdata_reg, reg_rdata_next;

  logic trigger;
  logic hram;
  logic last_clk;
  logic unused_rd;

  // Read strobes do not change blocking: the upstream mux suppresses any access.
  assign unused_rd = cpu_rd;
  assign trigger   = cpu_wr && (cpu_addr == 16'hFF46);
  assign hram      = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
  assign last_clk  = (cnt_reg == CNT_LAST);
  assign reg_rdata = reg_rdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      src_hi_reg    <= '0;
      reg_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      src_hi_reg    <= src_hi_next;
      reg_rdata_reg <= reg_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    src_hi_next    = src_hi_reg;
    reg_rdata_next = reg_rdata_reg;
    cpu_block      = 1'b0;
    mem_addr       = 16'h0000;
    mem_rd         = 1'b0;
    oam_addr       = 8'h00;
    oam_wdata      = 8'h00;
    oam_wr         = 1'b0;
    dma_active     = 1'b0;

    case (state_reg)
      START: begin
        dma_active = 1'b1;
        if (last_clk) begin
          state_next = XFER;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      XFER: begin
        dma_active = 1'b1;
        mem_rd     = 1'b1;
        mem_addr   = {src_hi_reg, idx_reg};
        cpu_block  = !hram;
        if (last_clk) begin
          oam_wr    = 1'b1;
          oam_addr  = idx_reg;
          oam_wdata = mem_rdata;
          cnt_next  = '0;
          idx_next  = idx_reg + 8'd1;
          if (idx_reg == IDX_LAST) state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: ;
    endcase

    // A new trigger restarts from scratch; echo-RAM pages fold down onto WRAM.
    if (trigger) begin
      reg_rdata_next = cpu_wdata;
      src_hi_next    = (cpu_wdata >= 8'hE0) ? (cpu_wdata - 8'h20) : cpu_wdata;
      state_next     = START;
      cnt_next       = '0;
      idx_next       = '0;
      cpu_block      = 1'b0;
      oam_wr         = 1'b0;
      oam_addr       = 8'h00;
      oam_wdata      = 8'h00;
    end

    if (rst) begin
      oam_wr    = 1'b0;
      oam_addr  = 8'h00;
      oam_wdata = 8'h00;
    end
  end

endmodule

// File: doc/gb_oam_dma.md
Name: gb_oam_dma

Overview:
- OAM DMA controller for the GameBoy memory system. Implements register $FF46.
- A CPU write to $FF46 starts a 160-byte copy from source page XX00–XX9F into OAM FE00–FE9F.
- While the copy runs, the block owns the external read bus (cartridge via MBC1, WRAM, VRAM) and blocks CPU accesses outside HRAM.
- It sits between the CPU bus decoder and the memory/OAM datapath, inside Top.

Parameters:
- BYTE_CLKS, 4, clk cycles per transferred byte (one M-cycle); legal range 2..15.
- NUM_BYTES, 160, bytes per transfer; legal range 1..256.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU bus address.
- cpu_wr  in  1  CPU write strobe; one clk per access.
- cpu_rd  in  1  CPU read strobe.
- cpu_wdata  in  8  CPU write data.
- reg_rdata  out  8  last value written to $FF46; registered.
- cpu_block  out  1  CPU access must be suppressed; reads return 0xFF (the muxing is done upstream).
- mem_addr  out  16  DMA source address to the memory mux.
- mem_rd  out  1  DMA owns the memory bus and reads.
- mem_rdata  in  8  source data; valid by the final clk of each byte period (memories are clocked on ~clk).
- oam_addr  out  8  OAM byte index.
- oam_wdata  out  8  OAM write data.
- oam_wr  out  1  OAM write strobe, one clk.
- dma_active  out  1  transfer in progress, including the start delay.

Behaviour:
Reset:
- State IDLE.
- reg_rdata=0x00, mem_addr=0x0000, mem_rd=0, oam_addr=0, oam_wdata=0, oam_wr=0, dma_active=0.
- Byte index and clk counter cleared.
- rst mid-transfer aborts immediately; no further oam_wr pulses.

Trigger:
- A trigger is a posedge where cpu_wr=1 and cpu_addr=0xFF46.
- On trigger: reg_rdata<=cpu_wdata, src_hi<=cpu_wdata, state<=START, counter<=0, index<=0.
- Source remap: if cpu_wdata>=0xE0, src_hi<=cpu_wdata-0x20 (echo RAM maps to WRAM). reg_rdata still holds the raw value.

States:
- IDLE: outputs inactive. A trigger goes to START.
- START:
  - dma_active=1, mem_rd=0, cpu_block not asserted.
  - Lasts BYTE_CLKS clks, then goes to XFER.
- XFER:
  - dma_active=1, mem_rd=1, mem_addr={src_hi, index}.
  - The counter runs 0..BYTE_CLKS-1.
  - On counter=BYTE_CLKS-1: oam_wr=1, oam_addr=index, oam_wdata=mem_rdata (combinational pass-through of the sampled byte in that clk); index increments and the counter wraps.
  - After the write of index NUM_BYTES-1, go to IDLE. dma_active and mem_rd drop on the next clk.

cpu_block:
- Combinational: (state==XFER) && !(0xFF80 <= cpu_addr <= 0xFFFE).
- Accesses to $FF46 itself are blocked for reads but never for the trigger write.

Restart:
- A trigger in START or XFER restarts at START with the new source and index 0.
- Any oam_wr due in that same clk is suppressed.

Other rules:
- Index width is 8 bits; with NUM_BYTES=256 it wraps to 0 exactly at completion.
- Latency: with write at clk T, byte k is written at T+BYTE_CLKS*(k+2). The last write (default config) is at T+644; dma_active=0 from T+645.
- A trigger simultaneous with rst is ignored (reset wins).

Test Plan:
1. rst, then write 0xC1 to FF46 at clk T:
   - dma_active=1 from T+1.
   - mem_addr=0xC100 from T+5.
   - First oam_wr at T+8 with oam_addr=0x00 and oam_wdata equal to mem[C100].
   - Last write oam_addr=0x9F at T+644.
   - dma_active=0 at T+645.
   - reg_rdata=0xC1.
2. During XFER:
   - cpu_addr=0xFF85 gives cpu_block=0.
   - cpu_addr=0xC000 gives cpu_block=1.
   - cpu_addr=0xFFFF gives cpu_block=1.
   - During START, cpu_addr=0xC000 gives cpu_block=0.
3. Write 0xE3:
   - mem_addr runs 0xC300..0xC39F.
   - reg_rdata=0xE3.
4. Write 0xC0, then at byte 50 write 0xD0:
   - No oam_wr on the restart clk.
   - Index restarts at 0.
   - mem_addr=0xD000 after the 4-clk START.
   - Exactly 160 further writes.
5. Assert rst at byte 10:
   - No oam_wr after reset.
   - All outputs return to reset values the next clk.
6. Write 0x00 (cartridge ROM via MBC1):
   - The 160 OAM bytes match ROM 0x0000–0x009F in order.
   - No gaps or duplicates.
